// File: rtl/sr_ctrl_pkg.sv
// sr_ctrl_pkg: shared state encoding and tap constants for the delay-line tap sequencer
package sr_ctrl_pkg;
    localparam int TAP_W = 5;
    localparam logic [TAP_W-1:0] TAP_MAX = 5'd31;
    localparam int SRL_DEPTH = 32;
    typedef enum logic [2:0] {IDLE, COMMIT, SETTLE, SCAN_ARM, SCAN_WAIT} state_t;
endpackage

// File: rtl/sr_settle_timer.sv
// sr_settle_timer: reloadable settle countdown; expire flags the last counting cycle
module sr_settle_timer #(
    parameter int SETTLE_CYC = 34
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic expire
);
    localparam int CW = $clog2(SETTLE_CYC + 1);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk) begin
        if (rst || load) cnt <= CW'(SETTLE_CYC);
        else if (cnt != '0) cnt <= cnt - CW'(1);
    end
    assign expire = cnt == CW'(1);
endmodule

// File: rtl/sr_tap_ctrl.sv
// sr_tap_ctrl: stages delay-line tap/bypass settings, commits them on trigger boundaries and runs tap scans
module sr_tap_ctrl import sr_ctrl_pkg::*; #(
    parameter int NUM_CH = 4,
    parameter int CH_W = 2,
    parameter int SETTLE_CYC = SRL_DEPTH + 2,
    parameter logic [TAP_W-1:0] TAP_RST = 5'd2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_we,
    input  logic [CH_W-1:0]         cfg_chan,
    input  logic [TAP_W-1:0]        cfg_tap,
    input  logic                    cfg_bypass,
    input  logic                    trig,
    input  logic                    scan_start,
    input  logic [CH_W-1:0]         scan_chan,
    output logic [NUM_CH*TAP_W-1:0] tap_out,
    output logic [NUM_CH-1:0]       bypass_out,
    output logic                    data_valid,
    output logic                    pending,
    output logic                    scan_active,
    output logic                    scan_done,
    output logic                    cfg_err
);
    state_t state, state_n;
    logic [NUM_CH-1:0][TAP_W-1:0] tap_q, stg_tap, snap_tap;
    logic [NUM_CH-1:0] byp_q, stg_byp, snap_byp;
    logic [CH_W-1:0] sc_ch;
    logic [TAP_W-1:0] sv_tap, sc_tap, arm_tap;
    logic sv_byp, arm_byp;
    logic cfg_ok, scan_ok, cfg_bad, expire, timer_load, final_step;

    assign cfg_ok = cfg_we && 32'(cfg_chan) < NUM_CH && !scan_active && state != SCAN_ARM;
    assign scan_ok = scan_start && state == IDLE && 32'(scan_chan) < NUM_CH;
    assign cfg_bad = (cfg_we && !cfg_ok) || (scan_start && !scan_ok);
    assign timer_load = state == COMMIT || state == SCAN_ARM;
    assign tap_out = tap_q;
    assign bypass_out = byp_q;

    sr_settle_timer #(.SETTLE_CYC(SETTLE_CYC)) u_timer (
        .clk(clk), .rst(rst), .load(timer_load), .expire(expire)
    );

    // Scan steps pass through COMMIT so they share the commit latency.
    always_comb begin
        sc_tap = '0;
        arm_tap = '0;
        arm_byp = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            sc_tap = (sc_ch == CH_W'(k)) ? tap_q[k] : sc_tap;
            arm_tap = (scan_chan == CH_W'(k)) ? stg_tap[k] : arm_tap;
            arm_byp = (scan_chan == CH_W'(k)) ? stg_byp[k] : arm_byp;
        end
        final_step = state == SETTLE && expire && scan_active && sc_tap == TAP_MAX;
        state_n = state;
        case (state)
            IDLE:      state_n = scan_ok ? SCAN_ARM : (trig && pending) ? COMMIT : IDLE;
            COMMIT:    state_n = SETTLE;
            SCAN_ARM:  state_n = SETTLE;
            SETTLE:    state_n = !expire ? SETTLE : (scan_active && sc_tap != TAP_MAX) ? SCAN_WAIT : IDLE;
            SCAN_WAIT: state_n = trig ? COMMIT : SCAN_WAIT;
            default:   state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SETTLE;
            tap_q <= {NUM_CH{TAP_RST}};
            byp_q <= '1;
            stg_tap <= {NUM_CH{TAP_RST}};
            stg_byp <= '1;
            snap_tap <= {NUM_CH{TAP_RST}};
            snap_byp <= '1;
            sc_ch <= '0;
            sv_tap <= TAP_RST;
            sv_byp <= 1'b1;
            data_valid <= 1'b0;
            pending <= 1'b0;
            scan_active <= 1'b0;
            scan_done <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            state <= state_n;
            pending <= stg_tap != tap_q || stg_byp != byp_q;
            scan_done <= final_step;
            cfg_err <= cfg_err | cfg_bad;
            if (state_n == COMMIT || state_n == SCAN_ARM) data_valid <= 1'b0;
            if (state == SETTLE && expire) data_valid <= 1'b1;
            // Snapshot at the trigger so a same-cycle write lands in stage only.
            if (state == IDLE && state_n == COMMIT) begin
                snap_tap <= stg_tap;
                snap_byp <= stg_byp;
            end
            if (scan_ok) begin
                sc_ch <= scan_chan;
                sv_tap <= arm_tap;
                sv_byp <= arm_byp;
            end
            if (state == SCAN_ARM) scan_active <= 1'b1;
            if (final_step) scan_active <= 1'b0;
            if (state == COMMIT && !scan_active) begin
                tap_q <= snap_tap;
                byp_q <= snap_byp;
            end
            for (int k = 0; k < NUM_CH; k++) begin
                if (cfg_ok && cfg_chan == CH_W'(k)) begin
                    stg_tap[k] <= cfg_tap;
                    stg_byp[k] <= cfg_bypass;
                end
                if (sc_ch == CH_W'(k)) begin
                    if (state == SCAN_ARM) begin
                        tap_q[k] <= '0;
                        byp_q[k] <= 1'b0;
                    end
                    if (state == COMMIT && scan_active) tap_q[k] <= tap_q[k] + TAP_W'(1);
                    if (final_step) begin
                        tap_q[k] <= sv_tap;
                        byp_q[k] <= sv_byp;
                    end
                end
            end
        end
    end
endmodule

// File: doc/sr_tap_ctrl.md
Name: sr_tap_ctrl

Overview:
Configuration sequencer for a bank of NUM_CH 13-bit programmable delay lines (32-deep SRL, tap 0..31, bypass select). It holds the staged tap and bypass settings written over the register interface, and commits them only at a trigger (inter-pulse) boundary. It then flags the delayed data as invalid while the delay lines refill. A scan mode steps one channel's tap 0..31, one step per trigger, for timing-alignment calibration.

Parameters:
NUM_CH, 4, number of delay-line channels driven
CH_W, 2, channel index width (clog2 NUM_CH)
SETTLE_CYC, 34, cycles data_valid stays low after a commit (32-deep line + 2 pipeline stages)
TAP_RST, 5'd2, tap value loaded on reset

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
cfg_we  in  1  stage-write strobe, one cycle
cfg_chan  in  CH_W  channel index for cfg_we
cfg_tap  in  5  staged tap value
cfg_bypass  in  1  staged bypass value
trig  in  1  inter-pulse boundary strobe, one cycle
scan_start  in  1  start tap scan, one cycle
scan_chan  in  CH_W  channel to scan
tap_out  out  NUM_CH*5  committed taps; channel k occupies bits [5k+4:5k]
bypass_out  out  NUM_CH  committed bypass bits
data_valid  out  1  delayed data is trustworthy
pending  out  1  staged settings differ from committed settings
scan_active  out  1  scan in progress
scan_done  out  1  one-cycle pulse after the final scan step settles
cfg_err  out  1  sticky flag: cfg_we or scan_start rejected; cleared by rst only

Behaviour:
- Reset values:
  - tap_out: all channels = TAP_RST
  - bypass_out: all 1
  - staged registers: equal to committed
  - data_valid = 0; settle counter loaded with SETTLE_CYC; FSM in SETTLE
  - pending, scan_active, scan_done, cfg_err = 0
- Staging:
  - cfg_we updates stage[cfg_chan] on the next edge.
  - cfg_chan >= NUM_CH: write ignored, cfg_err set.
  - cfg_we while scan_active: write ignored, cfg_err set.
- pending is registered: 1 whenever any stage entry differs from its committed entry.
- FSM states:
  - IDLE -> COMMIT on trig when pending = 1.
  - IDLE -> SCAN_ARM on scan_start.
  - COMMIT (1 cycle): copy all stage entries to committed outputs; load settle counter = SETTLE_CYC; data_valid <= 0; go to SETTLE.
  - SETTLE: decrement the counter each cycle. At 0, data_valid <= 1, then:
    - scan_active = 1: go to SCAN_WAIT, or to IDLE if the final step is done.
    - otherwise: go to IDLE.
  - SCAN_ARM (1 cycle):
    - Latch scan_chan.
    - Save that channel's pre-scan stage entry.
    - Set tap_out[scan_chan] = 0 and bypass_out[scan_chan] = 0.
    - Set scan_active = 1; go to SETTLE.
  - SCAN_WAIT:
    - On trig, tap_out[scan_chan] increments; go to SETTLE.
    - After the step with tap = 31 settles: restore the saved entry to the channel's committed output, pulse scan_done, clear scan_active, go to IDLE.
    - Restoring does not by itself start another settle.
- Latency:
  - Commit: trig at cycle t -> tap_out changes at t+2 -> data_valid rises at t+2+SETTLE_CYC.
  - Same timing for each scan step.
- Boundary conditions:
  - trig while in COMMIT or SETTLE: ignored. A later trig applies the staged changes.
  - cfg_we in the same cycle as a committing trig: the write is captured in stage, not in this commit. pending stays 1.
  - scan_start when not in IDLE: ignored, cfg_err set.
  - scan_chan >= NUM_CH: ignored, cfg_err set.
  - Tap arithmetic is unsigned 5-bit. The scan never wraps: it stops at 31.
  - rst mid-operation (in any state) forces the reset values on the next edge and aborts a scan without restoring.
- Channels other than the one being committed or scanned keep their outputs unchanged.
- data_valid is global: low whenever any channel is settling.

Decomposition:
- Shared package sr_ctrl_pkg holds:
  - FSM state encoding (IDLE, COMMIT, SETTLE, SCAN_ARM, SCAN_WAIT)
  - TAP_W = 5
  - TAP_MAX = 31
  - SRL_DEPTH = 32
- One sub-module, sr_settle_timer: load, count-down and done output, parameterised by SETTLE_CYC.
- The staging/commit register array stays inline.

Test Plan:
1. Reset release -> tap_out = {2,2,2,2}, bypass_out = 4'b1111, data_valid low for 34 cycles then high, pending = 0.
2. cfg_we ch1 tap = 7 bypass = 0, then trig at t:
   - pending = 1 before trig
   - tap_out[9:5] = 7 and bypass_out[1] = 0 at t+2
   - data_valid low from t+1 until t+36
   - pending = 0 after the commit
3. Second trig during SETTLE, with a new cfg_we to ch2 tap = 12 issued in the same cycle as the first trig:
   - ch2 not committed by the first trig
   - pending stays 1
   - next trig in IDLE commits tap = 12
4. cfg_chan = 3'd5 with NUM_CH = 4 and CH_W = 3 -> no output change, cfg_err = 1 and stays 1 until rst.
5. scan_start ch0, then 32 trigs spaced more than 40 cycles apart:
   - tap_out[4:0] runs 0, 1, …, 31
   - scan_done is a single pulse after the final settle
   - ch0 then restored to its pre-scan tap and bypass
   - a cfg_we during the scan sets cfg_err
6. rst asserted in SCAN_WAIT at tap = 15 -> next edge: all taps = 2, bypass = 1, scan_active = 0, no scan_done pulse, data_valid = 0.
